// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: FSM states, master IDs
// and the data pattern returned when a read is aborted.
package regfile_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // Replicated across the data width to form the all-ones error word.
  localparam logic RD_ERR_FILL = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Combinational two-way picker. Returns the winning master ID and a valid
// flag. Default build: round-robin on ties using the last-winner bit.
// With ARB_FIXED_PRIORITY_EN defined, M0 always wins and last_i is ignored.
module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o,
  output logic valid_o
);

  assign valid_o = req0_i | req1_i;

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = last_i;

  // Fixed priority: M0 whenever it asks.
  always_comb begin
    winner_o = req0_i ? MST_M0 : MST_M1;
  end
`else
  // Round-robin: on a tie the master that did not win last time goes next.
  always_comb begin
    if (req0_i && req1_i) begin
      winner_o = (last_i == MST_M0) ? MST_M1 : MST_M0;
    end else begin
      winner_o = req0_i ? MST_M0 : MST_M1;
    end
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Two-master arbiter in front of a single-port register file. One
// transaction in flight; read data is routed back to the owning master and
// reads that never complete are aborted with an all-ones word and RD_ERR.
// Optional: define ARB_FIXED_PRIORITY_EN for fixed M0-first priority.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned RD_TIMEOUT = 15,
  parameter int unsigned TO_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             M0_REQ,
  input  logic             M0_WE,
  input  logic [ASIZE-1:0] M0_ADDR,
  input  logic [DSIZE-1:0] M0_WDATA,
  output logic             M0_GNT,
  output logic [DSIZE-1:0] M0_RDATA,
  output logic             M0_RVALID,
  input  logic             M1_REQ,
  input  logic             M1_WE,
  input  logic [ASIZE-1:0] M1_ADDR,
  input  logic [DSIZE-1:0] M1_WDATA,
  output logic             M1_GNT,
  output logic [DSIZE-1:0] M1_RDATA,
  output logic             M1_RVALID,
  output logic             RD_ERR,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ASIZE-1:0] Address,
  output logic [DSIZE-1:0] WrData,
  input  logic [DSIZE-1:0] RdData,
  input  logic             RdData_Valid
);

  // The increment that lands on RD_TIMEOUT triggers the abort, so a read
  // spends at most RD_TIMEOUT cycles in WAIT_RD.
  localparam logic [TO_W-1:0] ToLast = TO_W'(RD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] CntOne = TO_W'(1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DSIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;

  logic             pick, pick_valid, pick_we, last_bit;
  logic [ASIZE-1:0] pick_addr;
  logic [DSIZE-1:0] pick_wdata;

`ifdef ARB_FIXED_PRIORITY_EN
  assign last_bit = MST_M1;
`else
  logic last_q, last_d;
  assign last_bit = last_q;
`endif

  rr_arb2 u_rr_arb2 (
    .req0_i  (M0_REQ),
    .req1_i  (M1_REQ),
    .last_i  (last_bit),
    .winner_o(pick),
    .valid_o (pick_valid)
  );

  // Route the winning master's request fields.
  always_comb begin
    pick_we    = (pick == MST_M0) ? M0_WE    : M1_WE;
    pick_addr  = (pick == MST_M0) ? M0_ADDR  : M1_ADDR;
    pick_wdata = (pick == MST_M0) ? M0_WDATA : M1_WDATA;
  end

  // Next-state and next-output logic; all pulses default low.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rd_err_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          owner_d = pick;
`ifndef ARB_FIXED_PRIORITY_EN
          last_d  = pick;
`endif
          addr_d  = pick_addr;
          wdata_d = pick_we ? pick_wdata : '0;
          wr_en_d = pick_we;
          rd_en_d = ~pick_we;
          gnt0_d  = (pick == MST_M0);
          gnt1_d  = (pick == MST_M1);
        end
      end
      ISSUE: begin
        state_d = wr_en_q ? IDLE : WAIT_RD;
        cnt_d   = '0;
      end
      WAIT_RD: begin
        cnt_d = cnt_q + CntOne;
        // Valid data takes precedence over a coincident timeout.
        if (RdData_Valid) begin
          state_d = IDLE;
          if (owner_q == MST_M0) begin
            rdata0_d  = RdData;
            rvalid0_d = 1'b1;
          end else begin
            rdata1_d  = RdData;
            rvalid1_d = 1'b1;
          end
        end else if (cnt_q == ToLast) begin
          state_d  = IDLE;
          rd_err_d = 1'b1;
          if (owner_q == MST_M0) begin
            rdata0_d  = {DSIZE{RD_ERR_FILL}};
            rvalid0_d = 1'b1;
          end else begin
            rdata1_d  = {DSIZE{RD_ERR_FILL}};
            rvalid1_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset parks the pointer on M1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      owner_q   <= MST_M0;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rd_err_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q    <= MST_M1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rd_err_q  <= rd_err_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q    <= last_d;
`endif
    end
  end

  assign M0_GNT    = gnt0_q;
  assign M1_GNT    = gnt1_q;
  assign M0_RVALID = rvalid0_q;
  assign M1_RVALID = rvalid1_q;
  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;
  assign RD_ERR    = rd_err_q;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: stimulus pushes expected output
// events (with the cycle they must appear in); a negedge monitor pops and
// compares whenever the DUT shows any grant, strobe or read completion.
`timescale 1ns/1ps
module tb_regfile_arbiter;

  localparam int DSIZE      = 8;
  localparam int ASIZE      = 4;
  localparam int RD_TIMEOUT = 15;
  localparam int TO_W       = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             M0_REQ = 1'b0, M0_WE = 1'b0;
  logic [ASIZE-1:0] M0_ADDR = '0;
  logic [DSIZE-1:0] M0_WDATA = '0;
  logic             M1_REQ = 1'b0, M1_WE = 1'b0;
  logic [ASIZE-1:0] M1_ADDR = '0;
  logic [DSIZE-1:0] M1_WDATA = '0;
  logic             M0_GNT, M0_RVALID, M1_GNT, M1_RVALID, RD_ERR, WrEn, RdEn;
  logic [DSIZE-1:0] M0_RDATA, M1_RDATA, WrData;
  logic [ASIZE-1:0] Address;
  logic [DSIZE-1:0] RdData;
  logic             RdData_Valid;

  regfile_arbiter #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .RD_TIMEOUT(RD_TIMEOUT), .TO_W(TO_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_GNT(M0_GNT), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_GNT(M1_GNT), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
    .RD_ERR(RD_ERR), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register file model: one-cycle read latency, reads gated by rf_en.
  logic [DSIZE-1:0] mem [16];
  logic rf_en = 1'b1;
  logic rf_vld;
  logic force_vld = 1'b0;
  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    RdData <= mem[Address];
    if (!RST) rf_vld <= 1'b0;
    else      rf_vld <= RdEn & rf_en;
  end
  assign RdData_Valid = rf_vld | force_vld;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] flags;  // {gnt0, gnt1, wr, rd, rv0, rv1, err}
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic exp_gnt(input string nm, input int c, input logic m, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.name  = nm;
    e.cyc   = c;
    e.flags = {!m, m, we, !we, 3'b000};
    e.addr  = a;
    e.wdata = we ? d : 8'h00;
    e.rdata = 8'h00;
    sb.push_back(e);
  endtask

  task automatic exp_rv(input string nm, input int c, input logic m, input logic err,
                        input logic [3:0] a, input logic [7:0] rd);
    exp_t e;
    e.name  = nm;
    e.cyc   = c;
    e.flags = {4'b0000, !m, m, err};
    e.addr  = a;
    e.wdata = 8'h00;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Monitor: any visible event must match the head of the scoreboard.
  always @(negedge CLK) begin : mon
    exp_t       e;
    logic [6:0] fl;
    logic [7:0] rd;
    if (RST) begin
      fl = {M0_GNT, M1_GNT, WrEn, RdEn, M0_RVALID, M1_RVALID, RD_ERR};
      if (fl != 7'd0) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got cyc=%0d flags=%b addr=%h, required no event",
                   cyc, fl, Address);
        end else begin
          e  = sb.pop_front();
          rd = e.flags[2] ? M0_RDATA : (e.flags[1] ? M1_RDATA : 8'h00);
          if (cyc != e.cyc || fl != e.flags || Address != e.addr || WrData != e.wdata ||
              rd != e.rdata) begin
            miscompares++;
            $display({"FAIL %s: got cyc=%0d flags=%b addr=%h wdata=%h rdata=%h, ",
                      "required cyc=%0d flags=%b addr=%h wdata=%h rdata=%h"},
                     e.name, cyc, fl, Address, WrData, rd,
                     e.cyc, e.flags, e.addr, e.wdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_zero(input string nm);
    logic [49:0] all;
    all = {M0_GNT, M0_RDATA, M0_RVALID, M1_GNT, M1_RDATA, M1_RVALID,
           RD_ERR, WrEn, RdEn, Address, WrData};
    vectors++;
    if (all != '0) begin
      miscompares++;
      $display("FAIL %s: got outputs=%h, required all zero", nm, all);
    end
  endtask

  task automatic set_req(input logic m, input logic v, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
    if (m == 1'b0) begin
      M0_REQ = v; M0_WE = we; M0_ADDR = a; M0_WDATA = d;
    end else begin
      M1_REQ = v; M1_WE = we; M1_ADDR = a; M1_WDATA = d;
    end
  endtask

  task automatic wait_gnt(input logic m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (m ? M1_GNT : M0_GNT) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL gnt_timeout: got no GNT for m%0d in 20 cycles, required a GNT", m);
    end
  endtask

  // Present one request, hold it until GNT, then drop it.
  task automatic issue(input logic m, input logic we, input logic [3:0] a,
                       input logic [7:0] d);
    set_req(m, 1'b1, we, a, d);
    wait_gnt(m);
    set_req(m, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr_txn(input string nm, input logic m, input logic [3:0] a,
                        input logic [7:0] d);
    int t;
    tick();
    t = cyc;
    exp_gnt(nm, t + 1, m, 1'b1, a, d);
    issue(m, 1'b1, a, d);
    tick();
  endtask

  task automatic rd_txn(input string nm, input logic m, input logic [3:0] a,
                        input int lat, input logic err, input logic [7:0] rd);
    int t;
    tick();
    t = cyc;
    exp_gnt(nm, t + 1, m, 1'b0, a, 8'h00);
    exp_rv(nm, t + lat, m, err, a, rd);
    issue(m, 1'b0, a, 8'h00);
    wait_until(t + lat + 1);
  endtask

  // Both masters hold write requests for four grants.
  task automatic tie4(input string nm);
    int t;
    int n;
    tick();
    t = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_gnt(nm, t + 1 + 2 * k, 1'b0, 1'b1, 4'h8, 8'h11);
`else
      if (k % 2 == 0) exp_gnt(nm, t + 1 + 2 * k, 1'b0, 1'b1, 4'h8, 8'h11);
      else            exp_gnt(nm, t + 1 + 2 * k, 1'b1, 1'b1, 4'h9, 8'h22);
`endif
    end
    set_req(1'b0, 1'b1, 1'b1, 4'h8, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 4'h9, 8'h22);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge CLK);
      if (M0_GNT || M1_GNT) n++;
    end
    if (n < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_grants: got %0d grants, required 4", nm, n);
    end
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, required completion");
    $fatal(1);
  end

  initial begin : stim
    int t;
    // Reset state.
    tick(); tick();
    check_zero("reset_outputs");
    @(negedge CLK);
    RST = 1'b1;

    wr_txn("m0_write_a3", 1'b0, 4'h3, 8'h5A);
    wr_txn("m0_write_a5", 1'b0, 4'h5, 8'h77);
    rd_txn("m1_read_a5", 1'b1, 4'h5, 3, 1'b0, 8'h77);

    tie4("tie_after_reads");

    // Read that never completes: abort RD_TIMEOUT+1 cycles after ISSUE.
    rf_en = 1'b0;
    rd_txn("m0_read_timeout", 1'b0, 4'h3, RD_TIMEOUT + 2, 1'b1, 8'hFF);

    // Valid arriving on the last allowed WAIT_RD cycle wins over the timeout.
    tick();
    t = cyc;
    exp_gnt("m0_valid_at_limit", t + 1, 1'b0, 1'b0, 4'h3, 8'h00);
    exp_rv("m0_valid_at_limit", t + RD_TIMEOUT + 2, 1'b0, 1'b0, 4'h3, 8'h5A);
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    wait_until(t + RD_TIMEOUT + 1);
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    tick();
    rf_en = 1'b1;

    rd_txn("m1_read_after_err", 1'b1, 4'h3, 3, 1'b0, 8'h5A);

    // Reset in the middle of WAIT_RD; last winner before reset is M0.
    rf_en = 1'b0;
    tick();
    t = cyc;
    exp_gnt("m0_read_reset", t + 1, 1'b0, 1'b0, 4'h3, 8'h00);
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    repeat (4) tick();
    #2;
    RST = 1'b0;
    #1;
    check_zero("reset_mid_wait");
    @(negedge CLK);
    check_zero("reset_held");
    RST = 1'b1;
    rf_en = 1'b1;
    // Stale read-valid in IDLE must produce nothing.
    tick();
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    repeat (3) tick();

    tie4("tie_after_reset");

    // Back-to-back M0 writes to 0, 1, 2.
    tick();
    t = cyc;
    for (int k = 0; k < 3; k++)
      exp_gnt("m0_b2b_write", t + 1 + 2 * k, 1'b0, 1'b1, k[3:0], 8'hA0 + k[7:0]);
    for (int k = 0; k < 3; k++) begin
      set_req(1'b0, 1'b1, 1'b1, k[3:0], 8'hA0 + k[7:0]);
      wait_gnt(1'b0);
    end
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (4) tick();

    // Anything left on the scoreboard never appeared.
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no event, required flags=%b at cyc=%0d", e.name, e.flags, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single-port register file (write strobe, read strobe, address, write data in; read data and read-valid out) between two requesters.
- M0 is the UART command controller; M1 is the configuration/diagnostic master.
- Round-robin arbitration, one transaction in flight, read data routed back to the owning requester, read timeout protection.
- Sits between both masters and the register file in the main clock domain.

Parameters:
DSIZE, 8, data width of register file words
ASIZE, 4, register file address width
RD_TIMEOUT, 15, max WAIT_RD cycles before a read is aborted (1..2^TO_W-1)
TO_W, 4, timeout counter width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
M0_REQ  in  1  M0 request; held with M0_WE/ADDR/WDATA stable until M0_GNT
M0_WE  in  1  1 = write, 0 = read
M0_ADDR  in  ASIZE  M0 target address
M0_WDATA  in  DSIZE  M0 write data
M0_GNT  out  1  one-cycle pulse: M0 transaction issued
M0_RDATA  out  DSIZE  read data for M0, valid with M0_RVALID
M0_RVALID  out  1  one-cycle pulse: M0 read complete
M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_GNT, M1_RDATA, M1_RVALID: identical for M1
RD_ERR  out  1  one-cycle pulse with RVALID when a read timed out
WrEn  out  1  register file write strobe
RdEn  out  1  register file read strobe
Address  out  ASIZE  register file address
WrData  out  DSIZE  register file write data
RdData  in  DSIZE  register file read data
RdData_Valid  in  1  register file read-data valid

Behaviour:
- All outputs are registered. On reset (any time, including mid-transaction):
  - all outputs 0, state IDLE, timeout counter 0;
  - last-winner pointer = M1, so M0 wins the first tie.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Any REQ high selects a winner. A sole requester wins. With both high, the master that is not the last winner wins, and the pointer updates to the winner.
  - On the next edge: state ISSUE; Address, WrData (write) or 0 (read) latched from the winner; WrEn = WE, RdEn = ~WE; winner GNT = 1.
  - No REQ: stay IDLE, strobes 0.
- ISSUE (exactly one cycle):
  - Strobes and GNT high for this cycle only.
  - The requester drops or changes REQ after seeing GNT.
  - Write: next state IDLE. Read: next state WAIT_RD, counter cleared.
- WAIT_RD:
  - WrEn = RdEn = 0. Address holds.
  - Counter increments each cycle.
  - RdData_Valid high: on the next edge the owner's RDATA = RdData, owner RVALID = 1 for one cycle, state IDLE.
  - Counter reaches RD_TIMEOUT without valid: on the next edge owner RDATA = all-ones, RVALID = 1, RD_ERR = 1 for one cycle, state IDLE.
  - RdData_Valid in the same cycle as the timeout: valid data wins, no RD_ERR.
- Timing:
  - Request-to-GNT latency: 1 cycle.
  - Write throughput: one per 2 cycles.
  - Read with 1-cycle register file latency: REQ to RVALID = 3 cycles.
- Requests arriving during ISSUE/WAIT_RD wait; there is no queueing beyond the held REQ.
- RdData_Valid seen in IDLE or ISSUE is ignored.
- RDATA registers hold their last value between RVALID pulses.
- Non-owner RVALID is never asserted.
- Address is never altered by requests outside IDLE.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: M0 always wins ties, the pointer is unused/removed, and M1 may starve while M0 requests continuously.
- Undefined: round-robin as above, so no master waits more than one other transaction.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT_RD), master ID constants (MST_M0 = 0, MST_M1 = 1), read-error fill value (all-ones).
- One sub-module: rr_arb2, a combinational 2-way picker taking both REQs and the last-winner bit and returning the winner ID and a valid flag. It honours ARB_FIXED_PRIORITY_EN.

Test Plan:
- M0 write: M0_REQ = 1, WE = 1, ADDR = 3, WDATA = 0x5A from IDLE -> next cycle M0_GNT = 1, WrEn = 1, Address = 3, WrData = 0x5A; both low one cycle later.
- M1 read: register file returns 0x77 one cycle after RdEn -> M1_RVALID = 1 with M1_RDATA = 0x77 three cycles after request; M0_RVALID stays 0.
- Both REQ held high for four transactions after reset -> grants M0, M1, M0, M1. With ARB_FIXED_PRIORITY_EN: M0, M0, M0, M0.
- Read with RdData_Valid never asserted -> RVALID = 1, RDATA = 0xFF, RD_ERR = 1 exactly RD_TIMEOUT + 1 cycles after ISSUE; next request is serviced normally.
- RST low during WAIT_RD -> all outputs 0 immediately. After release, a stale RdData_Valid pulse produces no RVALID, and the first tie grants M0.
- Back-to-back M0 writes to addresses 0, 1, 2 -> WrEn pulses on every second cycle with matching Address/WrData; no lost or duplicated strobe.
